// File: rtl/status_serial_rx_pkg.sv
// Shared definitions for the alarm status link receiver: frame layout,
// standby length used by the transmitter, FSM states and the frame legality rule.
package status_serial_rx_pkg;

  localparam int MSG_W = 4;
  localparam int SB    = 3;

  localparam int ARMED_BIT = 0;
  localparam int ALARM_BIT = 1;
  localparam int S1_BIT    = 2;
  localparam int S2_BIT    = 3;

  localparam int BIT_CNT_W = $clog2(MSG_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    DRAIN
  } rx_state_e;

  // An alarm can only be raised while the system is armed.
  function automatic logic frame_legal(input logic [MSG_W-1:0] frame);
    return !(frame[ALARM_BIT] && !frame[ARMED_BIT]);
  endfunction

endpackage

// File: rtl/status_serial_rx_if.sv
// Status link bundle: serial lines towards the receiver, decoded status back out.
interface status_serial_rx_if;
  import status_serial_rx_pkg::*;

  logic             status_in;
  logic             status_send_in;
  logic [MSG_W-1:0] msg;
  logic             armed;
  logic             alarm;
  logic             sensor1;
  logic             sensor2;
  logic             frame_valid;
  logic             frame_error;
  logic             link_ok;

  modport master (
    output status_in, status_send_in,
    input  msg, armed, alarm, sensor1, sensor2, frame_valid, frame_error, link_ok
  );

  modport slave (
    input  status_in, status_send_in,
    output msg, armed, alarm, sensor1, sensor2, frame_valid, frame_error, link_ok
  );

endinterface

// File: rtl/status_serial_rx_sync_ff.sv
// N-stage flip-flop synchroniser; identical depth on every lane keeps lanes aligned.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state is only ever updated with <= so every stage samples
  // the value its predecessor held before the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/status_serial_rx.sv
// Alarm status link receiver: synchronises the serial lines, deserialises and
// validates frames, holds the decoded status and supervises the link.
module status_serial_rx
  import status_serial_rx_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int LINK_TIMEOUT = 32
) (
  input  logic              CLK,
  input  logic              RST,
  status_serial_rx_if.slave bus
);

  localparam int LINK_W = $clog2(LINK_TIMEOUT + 1);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_ONE  = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL = BIT_CNT_W'(MSG_W);
  localparam logic [LINK_W-1:0]    LINK_ONE     = LINK_W'(1);
  localparam logic [LINK_W-1:0]    LINK_MAX     = LINK_W'(LINK_TIMEOUT);

  logic s_send;
  logic s_data;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_send (
    .CLK (CLK),
    .RST (RST),
    .d_i (bus.status_send_in),
    .q_o (s_send)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_data (
    .CLK (CLK),
    .RST (RST),
    .d_i (bus.status_in),
    .q_o (s_data)
  );

  rx_state_e            state_q,    state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [MSG_W-1:0]     shift_q,    shift_d;
  logic [MSG_W-1:0]     msg_q,      msg_d;
  logic                 valid_q,    valid_d;
  logic                 error_q,    error_d;
  logic [LINK_W-1:0]    link_cnt_q, link_cnt_d;
  logic                 link_ok_q,  link_ok_d;

  // Frames are decided on the edge that leaves RECV, so the pulses are visible
  // during CHECK; CHECK accepts a new bit 0 exactly like IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    msg_d     = msg_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      IDLE, CHECK: begin
        if (s_send) begin
          shift_d   = {s_data, shift_q[MSG_W-1:1]};
          bit_cnt_d = BIT_CNT_ONE;
          state_d   = RECV;
        end else begin
          state_d   = IDLE;
        end
      end
      RECV: begin
        if (s_send) begin
          if (bit_cnt_q == BIT_CNT_FULL) begin
            error_d = 1'b1;
            state_d = DRAIN;
          end else begin
            shift_d   = {s_data, shift_q[MSG_W-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_CNT_ONE;
          end
        end else if (bit_cnt_q == BIT_CNT_FULL) begin
          state_d = CHECK;
          if (frame_legal(shift_q)) begin
            msg_d   = shift_q;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!s_send) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Link supervisor: a commit always wins over a coincident timeout.
  always_comb begin
    link_cnt_d = link_cnt_q;
    link_ok_d  = link_ok_q;
    if (valid_d) begin
      link_cnt_d = '0;
      link_ok_d  = 1'b1;
    end else if (link_cnt_q != LINK_MAX) begin
      link_cnt_d = link_cnt_q + LINK_ONE;
      if (link_cnt_d == LINK_MAX) begin
        link_ok_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      msg_q      <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      link_cnt_q <= '0;
      link_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      msg_q      <= msg_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      link_cnt_q <= link_cnt_d;
      link_ok_q  <= link_ok_d;
    end
  end

  assign bus.msg         = msg_q;
  assign bus.armed       = msg_q[ARMED_BIT];
  assign bus.alarm       = msg_q[ALARM_BIT];
  assign bus.sensor1     = msg_q[S1_BIT];
  assign bus.sensor2     = msg_q[S2_BIT];
  assign bus.frame_valid = valid_q;
  assign bus.frame_error = error_q;
  assign bus.link_ok     = link_ok_q;

endmodule
